jpeg_sof_parser: RTL and testbench

//  Byte-serial SOFn (baseline/extended) frame-header parser for N image components; successor to the fixed 3-component SOF block.

---
 rtl/jpeg_pkg.sv | 50 +++++
 rtl/jpeg_mcu_calc.sv | 34 +++
 rtl/jpeg_sof_parser.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_jpeg_sof_parser.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG header-parsing definitions: SOF parser state encoding,
// err_code values and the log2 lookup for the legal sampling factors {1,2,4}.
package jpeg_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LEN_H,
      ST_LEN_L,
      ST_PREC,
      ST_Y_H,
      ST_Y_L,
      ST_X_H,
      ST_X_L,
      ST_NF,
      ST_C_ID,
      ST_C_HV,
      ST_C_TQ,
      ST_CALC,
      ST_ERR,
      ST_DONE
   } sof_state_e;

   localparam logic [2:0] ERR_NONE = 3'd0;
   localparam logic [2:0] ERR_NF   = 3'd1;
   localparam logic [2:0] ERR_HV   = 3'd2;
   localparam logic [2:0] ERR_TQ   = 3'd3;
   localparam logic [2:0] ERR_DIM  = 3'd4;
   localparam logic [2:0] ERR_LF   = 3'd5;
   localparam logic [2:0] ERR_PREC = 3'd6;

   // Shift amount for a sampling factor; only 1, 2 and 4 ever reach the MCU maths.
   function automatic logic [1:0] hv_log2(input logic [2:0] hv);
      case (hv)
         3'd4:    return 2'd2;
         3'd2:    return 2'd1;
         default: return 2'd0;
      endcase
   endfunction

   // Sampling factors restricted to powers of two so every divide is a shift.
   function automatic logic hv_legal(input logic [3:0] f);
      return (f == 4'd1) || (f == 4'd2) || (f == 4'd4);
   endfunction

   // States in which a payload byte may be accepted.
   function automatic logic sof_consumes(input sof_state_e s);
      return !(s inside {ST_IDLE, ST_CALC, ST_ERR, ST_DONE});
   endfunction

endpackage

// File: rtl/jpeg_mcu_calc.sv
// MCU grid arithmetic: ceil(dim / (8*factor)) with factor in {1,2,4}.
// Ports: dim_x/dim_y image size, h_max/v_max max sampling factors,
//        mcu_w_c/mcu_h_c combinational MCU counts (truncated to MCU_W).
module jpeg_mcu_calc
   import jpeg_pkg::*;
#(
   parameter int unsigned MCU_W = 13
) (
   input  logic [15:0]      dim_x,
   input  logic [15:0]      dim_y,
   input  logic [2:0]       h_max,
   input  logic [2:0]       v_max,
   output logic [MCU_W-1:0] mcu_w_c,
   output logic [MCU_W-1:0] mcu_h_c
);

   localparam int unsigned SUM_W = 20;

   logic [SUM_W-1:0] sum_x;
   logic [SUM_W-1:0] sum_y;
   logic [2:0]       sh_x;
   logic [2:0]       sh_y;

   // Round up by adding (8*factor - 1) before the shift.
   always_comb begin
      sum_x   = SUM_W'(dim_x) + SUM_W'({h_max, 3'b000}) - SUM_W'(1);
      sum_y   = SUM_W'(dim_y) + SUM_W'({v_max, 3'b000}) - SUM_W'(1);
      sh_x    = 3'd3 + 3'(hv_log2(h_max));
      sh_y    = 3'd3 + 3'(hv_log2(v_max));
      mcu_w_c = MCU_W'(sum_x >> sh_x);
      mcu_h_c = MCU_W'(sum_y >> sh_y);
   end

endmodule

// File: rtl/jpeg_sof_parser.sv
// Byte-serial SOF0/SOF1 frame-header parser for up to MAX_COMP components.
// Consumes the segment payload after the marker, publishes image size,
// per-component id/H/V/Tq lanes (lane 0 = first in stream), Hmax/Vmax and
// the MCU grid, and flags malformed headers through err_code.
// Ports: clk/rst (sync, active-high); start, in_valid/in_data/in_ready byte
//        input; hdr_done pulse, hdr_valid/hdr_err levels, err_code; width,
//        height, ncomp, comp_id/h/v/qt lanes, h_max, v_max, mcu_w, mcu_h.
// Build option: define JPEG_SOF_STRICT_EN to check Lf == 8+3*Nf and P == 8.
module jpeg_sof_parser
   import jpeg_pkg::*;
#(
   parameter int unsigned MAX_COMP = 4,
   parameter int unsigned DIM_W    = 16,
   parameter int unsigned MCU_W    = 13
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  hdr_done,
   output logic                  hdr_valid,
   output logic                  hdr_err,
   output logic [2:0]            err_code,
   output logic [DIM_W-1:0]      width,
   output logic [DIM_W-1:0]      height,
   output logic [2:0]            ncomp,
   output logic [8*MAX_COMP-1:0] comp_id,
   output logic [3*MAX_COMP-1:0] comp_h,
   output logic [3*MAX_COMP-1:0] comp_v,
   output logic [2*MAX_COMP-1:0] comp_qt,
   output logic [2:0]            h_max,
   output logic [2:0]            v_max,
   output logic [MCU_W-1:0]      mcu_w,
   output logic [MCU_W-1:0]      mcu_h
);

   localparam int unsigned IDX_W = (MAX_COMP > 1) ? $clog2(MAX_COMP) : 1;

   sof_state_e       state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             hdr_done_q, hdr_done_d;
   logic             hdr_valid_q, hdr_valid_d;
   logic             hdr_err_q, hdr_err_d;
   logic [2:0]       err_code_q, err_code_d;
   logic [15:0]      x_q, x_d;
   logic [15:0]      y_q, y_d;
   logic [2:0]       nf_q, nf_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [2:0]       hmax_q, hmax_d;
   logic [2:0]       vmax_q, vmax_d;
   logic [MCU_W-1:0] mcu_w_q, mcu_w_d;
   logic [MCU_W-1:0] mcu_h_q, mcu_h_d;
   logic [7:0]       comp_id_q [MAX_COMP];
   logic [7:0]       comp_id_d [MAX_COMP];
   logic [2:0]       comp_h_q  [MAX_COMP];
   logic [2:0]       comp_h_d  [MAX_COMP];
   logic [2:0]       comp_v_q  [MAX_COMP];
   logic [2:0]       comp_v_d  [MAX_COMP];
   logic [1:0]       comp_qt_q [MAX_COMP];
   logic [1:0]       comp_qt_d [MAX_COMP];
`ifdef JPEG_SOF_STRICT_EN
   logic [15:0]      lf_q, lf_d;
`endif

   logic             acc_c;
   logic [3:0]       hf_c, vf_c;
   logic [2:0]       h_eff_c, v_eff_c;
   logic [MCU_W-1:0] calc_w_c, calc_h_c;

   // Grayscale frames use 1x1 MCUs whatever H1/V1 say.
   assign h_eff_c = (nf_q == 3'd1) ? 3'd1 : hmax_q;
   assign v_eff_c = (nf_q == 3'd1) ? 3'd1 : vmax_q;

   jpeg_mcu_calc #(.MCU_W(MCU_W)) u_mcu_calc (
      .dim_x   (x_q),
      .dim_y   (y_q),
      .h_max   (h_eff_c),
      .v_max   (v_eff_c),
      .mcu_w_c (calc_w_c),
      .mcu_h_c (calc_h_c)
   );

   // Next-state and output decode; one state advance per accepted byte.
   always_comb begin
      state_d     = state_q;
      hdr_done_d  = 1'b0;
      hdr_valid_d = hdr_valid_q;
      hdr_err_d   = hdr_err_q;
      err_code_d  = err_code_q;
      x_d         = x_q;
      y_d         = y_q;
      nf_d        = nf_q;
      idx_d       = idx_q;
      hmax_d      = hmax_q;
      vmax_d      = vmax_q;
      mcu_w_d     = mcu_w_q;
      mcu_h_d     = mcu_h_q;
      comp_id_d   = comp_id_q;
      comp_h_d    = comp_h_q;
      comp_v_d    = comp_v_q;
      comp_qt_d   = comp_qt_q;
`ifdef JPEG_SOF_STRICT_EN
      lf_d        = lf_q;
`endif
      acc_c       = in_valid && in_ready_q;
      hf_c        = in_data[7:4];
      vf_c        = in_data[3:0];

      if (start) begin
         // New marker wins over any byte presented in the same cycle.
         state_d     = ST_LEN_H;
         hdr_valid_d = 1'b0;
         hdr_err_d   = 1'b0;
         err_code_d  = ERR_NONE;
         x_d         = '0;
         y_d         = '0;
         nf_d        = '0;
         idx_d       = '0;
         hmax_d      = '0;
         vmax_d      = '0;
         mcu_w_d     = '0;
         mcu_h_d     = '0;
         for (int unsigned i = 0; i < MAX_COMP; i++) begin
            comp_id_d[i] = '0;
            comp_h_d[i]  = '0;
            comp_v_d[i]  = '0;
            comp_qt_d[i] = '0;
         end
      end else begin
         case (state_q)
            ST_LEN_H: if (acc_c) begin
`ifdef JPEG_SOF_STRICT_EN
               lf_d[15:8] = in_data;
`endif
               state_d = ST_LEN_L;
            end
            ST_LEN_L: if (acc_c) begin
`ifdef JPEG_SOF_STRICT_EN
               lf_d[7:0] = in_data;
`endif
               state_d = ST_PREC;
            end
            ST_PREC: if (acc_c) begin
               state_d = ST_Y_H;
`ifdef JPEG_SOF_STRICT_EN
               if (in_data != 8'd8) begin
                  err_code_d = ERR_PREC;
                  state_d    = ST_ERR;
               end
`endif
            end
            ST_Y_H: if (acc_c) begin
               y_d     = {in_data, y_q[7:0]};
               state_d = ST_Y_L;
            end
            ST_Y_L: if (acc_c) begin
               y_d     = {y_q[15:8], in_data};
               state_d = ST_X_H;
            end
            ST_X_H: if (acc_c) begin
               x_d     = {in_data, x_q[7:0]};
               state_d = ST_X_L;
            end
            ST_X_L: if (acc_c) begin
               x_d     = {x_q[15:8], in_data};
               state_d = ST_NF;
            end
            ST_NF: if (acc_c) begin
               // Later checks override earlier ones: Nf range has top priority.
               nf_d    = 3'(in_data);
               idx_d   = '0;
               state_d = ST_C_ID;
`ifdef JPEG_SOF_STRICT_EN
               if (lf_q != (16'd8 + 16'd3 * 16'(in_data))) begin
                  err_code_d = ERR_LF;
                  state_d    = ST_ERR;
               end
`endif
               if ((x_q == 16'd0) || (y_q == 16'd0)) begin
                  err_code_d = ERR_DIM;
                  state_d    = ST_ERR;
               end
               if ((in_data == 8'd0) || (in_data > 8'(MAX_COMP))) begin
                  err_code_d = ERR_NF;
                  state_d    = ST_ERR;
               end
            end
            ST_C_ID: if (acc_c) begin
               comp_id_d[idx_q] = in_data;
               state_d          = ST_C_HV;
            end
            ST_C_HV: if (acc_c) begin
               comp_h_d[idx_q] = 3'(hf_c);
               comp_v_d[idx_q] = 3'(vf_c);
               if (!hv_legal(hf_c) || !hv_legal(vf_c)) begin
                  err_code_d = ERR_HV;
                  state_d    = ST_ERR;
               end else begin
                  if (3'(hf_c) > hmax_q) hmax_d = 3'(hf_c);
                  if (3'(vf_c) > vmax_q) vmax_d = 3'(vf_c);
                  state_d = ST_C_TQ;
               end
            end
            ST_C_TQ: if (acc_c) begin
               comp_qt_d[idx_q] = in_data[1:0];
               if (in_data[3:2] != 2'b00) begin
                  err_code_d = ERR_TQ;
                  state_d    = ST_ERR;
               end else if ((3'(idx_q) + 3'd1) == nf_q) begin
                  state_d = ST_CALC;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = ST_C_ID;
               end
            end
            ST_CALC: begin
               mcu_w_d     = calc_w_c;
               mcu_h_d     = calc_h_c;
               hmax_d      = h_eff_c;
               vmax_d      = v_eff_c;
               hdr_done_d  = 1'b1;
               hdr_valid_d = 1'b1;
               state_d     = ST_DONE;
            end
            ST_ERR: begin
               hdr_done_d = 1'b1;
               hdr_err_d  = 1'b1;
               state_d    = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end

      // Registered ready tracks the state being entered.
      in_ready_d = sof_consumes(state_d);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b0;
         hdr_done_q  <= 1'b0;
         hdr_valid_q <= 1'b0;
         hdr_err_q   <= 1'b0;
         err_code_q  <= ERR_NONE;
         x_q         <= '0;
         y_q         <= '0;
         nf_q        <= '0;
         idx_q       <= '0;
         hmax_q      <= '0;
         vmax_q      <= '0;
         mcu_w_q     <= '0;
         mcu_h_q     <= '0;
         comp_id_q   <= '{default: '0};
         comp_h_q    <= '{default: '0};
         comp_v_q    <= '{default: '0};
         comp_qt_q   <= '{default: '0};
`ifdef JPEG_SOF_STRICT_EN
         lf_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         hdr_done_q  <= hdr_done_d;
         hdr_valid_q <= hdr_valid_d;
         hdr_err_q   <= hdr_err_d;
         err_code_q  <= err_code_d;
         x_q         <= x_d;
         y_q         <= y_d;
         nf_q        <= nf_d;
         idx_q       <= idx_d;
         hmax_q      <= hmax_d;
         vmax_q      <= vmax_d;
         mcu_w_q     <= mcu_w_d;
         mcu_h_q     <= mcu_h_d;
         comp_id_q   <= comp_id_d;
         comp_h_q    <= comp_h_d;
         comp_v_q    <= comp_v_d;
         comp_qt_q   <= comp_qt_d;
`ifdef JPEG_SOF_STRICT_EN
         lf_q        <= lf_d;
`endif
      end
   end

   assign in_ready  = in_ready_q;
   assign hdr_done  = hdr_done_q;
   assign hdr_valid = hdr_valid_q;
   assign hdr_err   = hdr_err_q;
   assign err_code  = err_code_q;
   assign width     = DIM_W'(x_q);
   assign height    = DIM_W'(y_q);
   assign ncomp     = nf_q;
   assign h_max     = hmax_q;
   assign v_max     = vmax_q;
   assign mcu_w     = mcu_w_q;
   assign mcu_h     = mcu_h_q;

   // Pack lane registers onto the flat per-component buses.
   for (genvar i = 0; i < MAX_COMP; i++) begin : g_lane
      assign comp_id[8*i +: 8] = comp_id_q[i];
      assign comp_h[3*i +: 3]  = comp_h_q[i];
      assign comp_v[3*i +: 3]  = comp_v_q[i];
      assign comp_qt[2*i +: 2] = comp_qt_q[i];
   end

endmodule

// File: tb/tb_jpeg_sof_parser.sv
// Self-checking bench for jpeg_sof_parser: header streams are driven byte by
// byte, a reference model pushes the expected result into a scoreboard, and a
// monitor pops and compares on every hdr_done pulse.
module tb_jpeg_sof_parser;

   localparam int unsigned MAX_COMP = 4;
   localparam int unsigned DIM_W    = 16;
   localparam int unsigned MCU_W    = 13;
`ifdef JPEG_SOF_STRICT_EN
   localparam bit STRICT = 1'b1;
`else
   localparam bit STRICT = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst, start, in_valid;
   logic [7:0]            in_data;
   logic                  in_ready, hdr_done, hdr_valid, hdr_err;
   logic [2:0]            err_code, ncomp, h_max, v_max;
   logic [DIM_W-1:0]      width, height;
   logic [8*MAX_COMP-1:0] comp_id;
   logic [3*MAX_COMP-1:0] comp_h, comp_v;
   logic [2*MAX_COMP-1:0] comp_qt;
   logic [MCU_W-1:0]      mcu_w, mcu_h;

   jpeg_sof_parser #(.MAX_COMP(MAX_COMP), .DIM_W(DIM_W), .MCU_W(MCU_W)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .hdr_done(hdr_done), .hdr_valid(hdr_valid), .hdr_err(hdr_err),
      .err_code(err_code), .width(width), .height(height), .ncomp(ncomp),
      .comp_id(comp_id), .comp_h(comp_h), .comp_v(comp_v), .comp_qt(comp_qt),
      .h_max(h_max), .v_max(v_max), .mcu_w(mcu_w), .mcu_h(mcu_h)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [15:0]      lf;
      logic [7:0]       prec;
      logic [15:0]      y;
      logic [15:0]      x;
      logic [7:0]       nf;
      logic [3:0][7:0]  id;
      logic [3:0][7:0]  hv;
      logic [3:0][7:0]  tq;
   } hdr_t;

   typedef struct {
      bit               full;
      logic             valid;
      logic             err;
      logic [2:0]       code;
      logic [15:0]      w;
      logic [15:0]      h;
      logic [2:0]       nc;
      logic [2:0]       hm;
      logic [2:0]       vm;
      logic [12:0]      mw;
      logic [12:0]      mh;
      logic [31:0]      ids;
      logic [11:0]      hs;
      logic [11:0]      vs;
      logic [7:0]       qs;
      int unsigned      done_cyc;
   } exp_t;

   exp_t sb[$];

   function automatic hdr_t mk(input logic [15:0] lf, input logic [15:0] y, input logic [15:0] x,
                               input logic [7:0] nf, input logic [31:0] id,
                               input logic [31:0] hv, input logic [31:0] tq);
      hdr_t h;
      h.lf = lf; h.prec = 8'd8; h.y = y; h.x = x; h.nf = nf;
      h.id = id; h.hv = hv; h.tq = tq;
      return h;
   endfunction

   function automatic bit legal(input logic [3:0] f);
      return (f == 4'd1) || (f == 4'd2) || (f == 4'd4);
   endfunction

   task automatic pulse_start();
      // A junk byte rides along with start and must not be consumed.
      @(negedge clk);
      start = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
      @(posedge clk); #1;
      start = 1'b0; in_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      bit done = 1'b0;
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      for (int t = 0; t < 100 && !done; t++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = b;
         if (in_ready) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            done = 1'b1;
         end
      end
      if (!done) begin
         in_valid = 1'b0;
         chk("ready_timeout", 32'(in_ready), 32'd1);
      end
   endtask

   // Reference model: decide outcome, send bytes up to the deciding one, push expectation.
   task automatic run_hdr(input hdr_t h, input bit gaps, input bit do_start);
      logic [7:0] b[$];
      exp_t       e;
      int         stop;
      int         code;
      int         nl;
      int         hm, vm;
      b = {h.lf[15:8], h.lf[7:0], h.prec, h.y[15:8], h.y[7:0], h.x[15:8], h.x[7:0], h.nf};
      nl = (int'(h.nf) < int'(MAX_COMP)) ? int'(h.nf) : int'(MAX_COMP);
      for (int i = 0; i < nl; i++) b.push_back(h.id[i]);
      for (int i = 0; i < nl; i++) begin
         b.insert(8 + 3*i + 1, h.hv[i]);
         b.insert(8 + 3*i + 2, h.tq[i]);
      end
      code = 0; stop = 0;
      if (STRICT && h.prec != 8'd8) begin code = 6; stop = 2; end
      if (code == 0) begin
         stop = 7;
         if (h.nf == 8'd0 || int'(h.nf) > int'(MAX_COMP)) code = 1;
         else if (h.x == 16'd0 || h.y == 16'd0) code = 4;
         else if (STRICT && int'(h.lf) != 8 + 3*int'(h.nf)) code = 5;
      end
      hm = 0; vm = 0;
      for (int i = 0; i < int'(h.nf) && code == 0; i++) begin
         if (!legal(h.hv[i][7:4]) || !legal(h.hv[i][3:0])) begin
            code = 2; stop = 9 + 3*i;
         end else if (h.tq[i][3:2] != 2'b00) begin
            code = 3; stop = 10 + 3*i;
         end else begin
            stop = 10 + 3*i;
            if (int'(h.hv[i][7:4]) > hm) hm = int'(h.hv[i][7:4]);
            if (int'(h.hv[i][3:0]) > vm) vm = int'(h.hv[i][3:0]);
         end
      end
      if (h.nf == 8'd1) begin hm = 1; vm = 1; end

      e.full = (code == 0);
      e.valid = (code == 0);
      e.err = (code != 0);
      e.code = 3'(code);
      e.w = h.x; e.h = h.y; e.nc = 3'(h.nf);
      e.hm = 3'(hm); e.vm = 3'(vm);
      e.mw = (hm == 0) ? 13'd0 : 13'((int'(h.x) + 8*hm - 1) / (8*hm));
      e.mh = (vm == 0) ? 13'd0 : 13'((int'(h.y) + 8*vm - 1) / (8*vm));
      e.ids = '0; e.hs = '0; e.vs = '0; e.qs = '0;
      for (int i = 0; i < nl; i++) begin
         e.ids[8*i +: 8] = h.id[i];
         e.hs[3*i +: 3]  = 3'(h.hv[i][7:4]);
         e.vs[3*i +: 3]  = 3'(h.hv[i][3:0]);
         e.qs[2*i +: 2]  = h.tq[i][1:0];
      end

      if (do_start) pulse_start();
      for (int i = 0; i <= stop; i++) send_byte(b[i], gaps);
      e.done_cyc = cyc + 1;
      sb.push_back(e);
      if (code == 1) begin
         @(negedge clk);
         chk("ready_after_nf", 32'(in_ready), 32'd0);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      chk("drain", 32'(sb.size()), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   // Monitor: pop and compare on each hdr_done pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (hdr_done) begin
            if (sb.size() == 0) begin
               chk("spurious_done", 32'(sb.size()), 32'd1);
            end else begin
               e = sb.pop_front();
               chk("latency", cyc, e.done_cyc);
               chk("hdr_valid", 32'(hdr_valid), 32'(e.valid));
               chk("hdr_err", 32'(hdr_err), 32'(e.err));
               chk("err_code", 32'(err_code), 32'(e.code));
               if (e.full) begin
                  chk("width", 32'(width), 32'(e.w));
                  chk("height", 32'(height), 32'(e.h));
                  chk("ncomp", 32'(ncomp), 32'(e.nc));
                  chk("h_max", 32'(h_max), 32'(e.hm));
                  chk("v_max", 32'(v_max), 32'(e.vm));
                  chk("mcu_w", 32'(mcu_w), 32'(e.mw));
                  chk("mcu_h", 32'(mcu_h), 32'(e.mh));
                  chk("comp_id", comp_id, e.ids);
                  chk("comp_h", 32'(comp_h), 32'(e.hs));
                  chk("comp_v", 32'(comp_v), 32'(e.vs));
                  chk("comp_qt", 32'(comp_qt), 32'(e.qs));
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_hdr_done", 32'(hdr_done), 32'd0);
      chk("rst_hdr_valid", 32'(hdr_valid), 32'd0);
      chk("rst_hdr_err", 32'(hdr_err), 32'd0);
      chk("rst_err_code", 32'(err_code), 32'd0);
      chk("rst_width", 32'(width), 32'd0);
      chk("rst_mcu_w", 32'(mcu_w), 32'd0);
      chk("rst_comp_id", comp_id, 32'd0);

      // 4:2:0 1080p
      run_hdr(mk(16'd17, 16'd1080, 16'd1920, 8'd3, 32'h00030201, 32'h00111122, 32'h00010100), 1'b0, 1'b1);
      drain();
      // Grayscale, upper lanes must read zero after the 3-component frame
      run_hdr(mk(16'd11, 16'd17, 16'd33, 8'd1, 32'h00000001, 32'h00000011, 32'h00000000), 1'b0, 1'b1);
      drain();
      // Factor-4 sampling in both directions
      run_hdr(mk(16'd14, 16'd64, 16'd100, 8'd2, 32'h00000201, 32'h00001441, 32'h00000302), 1'b1, 1'b1);
      drain();
      // Nf beyond MAX_COMP
      run_hdr(mk(16'd23, 16'd16, 16'd16, 8'd5, 32'h04030201, 32'h11111111, 32'h00000000), 1'b0, 1'b1);
      drain();
      // Illegal H=3
      run_hdr(mk(16'd17, 16'd16, 16'd16, 8'd3, 32'h00030201, 32'h00111131, 32'h00000000), 1'b0, 1'b1);
      drain();
      // Tq=4
      run_hdr(mk(16'd17, 16'd16, 16'd16, 8'd3, 32'h00030201, 32'h00111111, 32'h00000400), 1'b0, 1'b1);
      drain();
      // Zero width
      run_hdr(mk(16'd17, 16'd16, 16'd0, 8'd3, 32'h00030201, 32'h00111111, 32'h00000000), 1'b0, 1'b1);
      drain();
      // Lf off by one: error only in the strict build
      run_hdr(mk(16'd18, 16'd1080, 16'd1920, 8'd3, 32'h00030201, 32'h00111122, 32'h00010100), 1'b0, 1'b1);
      drain();

      // Abandon a header after Y_L, then restart with random stalls
      pulse_start();
      send_byte(8'h00, 1'b0); send_byte(8'h11, 1'b0); send_byte(8'h08, 1'b0);
      send_byte(8'h01, 1'b0); send_byte(8'hE0, 1'b0);
      pulse_start();
      @(negedge clk);
      chk("restart_hdr_valid", 32'(hdr_valid), 32'd0);
      chk("restart_hdr_err", 32'(hdr_err), 32'd0);
      chk("restart_height", 32'(height), 32'd0);
      chk("restart_in_ready", 32'(in_ready), 32'd1);
      run_hdr(mk(16'd17, 16'd480, 16'd640, 8'd3, 32'h00030201, 32'h00111121, 32'h00010100), 1'b1, 1'b0);
      drain();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
